// File: rtl/div_bcd_formatter.sv
// Formats the 4-bit divider result (quotient, remainder, divide-by-zero) as two-digit BCD.
// Define DIV_FMT_SEG7_EN to add the registered active-low 7-segment output "seg".
module div_bcd_formatter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  q,
    input  logic [3:0]  r,
    input  logic [3:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  q_bcd,
    output logic [7:0]  r_bcd,
    output logic        dz
`ifdef DIV_FMT_SEG7_EN
    ,
    output logic [27:0] seg
`endif
);

    // Handshakes: a word moves on the rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and nothing overlaps.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [11:0] q_dd_q, q_dd_d;
    logic [11:0] r_dd_q, r_dd_d;
    logic        dz_next_q, dz_next_d;
    logic [7:0]  q_bcd_q, q_bcd_d;
    logic [7:0]  r_bcd_q, r_bcd_d;
    logic        dz_q, dz_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [11:0] q_adj, r_adj;
    logic [11:0] q_step, r_step;

    // Working register is {bcd tens, bcd ones, binary source}; +3 on digits >= 5 before each shift.
    function automatic logic [11:0] dabble_adj(input logic [11:0] w);
        logic [11:0] res;
        res = w;
        if (res[7:4] >= 4'd5)
            res[7:4] = res[7:4] + 4'd3;
        if (res[11:8] >= 4'd5)
            res[11:8] = res[11:8] + 4'd3;
        return res;
    endfunction

`ifdef DIV_FMT_SEG7_EN
    logic [27:0] seg_q, seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_dd_d      = q_dd_q;
        r_dd_d      = r_dd_q;
        dz_next_d   = dz_next_q;
        q_bcd_d     = q_bcd_q;
        r_bcd_d     = r_bcd_q;
        dz_d        = dz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        q_adj       = dabble_adj(q_dd_q);
        r_adj       = dabble_adj(r_dd_q);
        q_step      = q_adj << 1;
        r_step      = r_adj << 1;
`ifdef DIV_FMT_SEG7_EN
        seg_d       = seg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_dd_d     = {8'h00, q};
                    r_dd_d     = {8'h00, r};
                    dz_next_d  = (b == 4'd0);
                    cnt_d      = 2'd0;
                    state_d    = CONV;
                    in_ready_d = 1'b0;
                end
            end
            CONV: begin
                q_dd_d = q_step;
                r_dd_d = r_step;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    q_bcd_d     = dz_next_q ? 8'h00 : q_step[11:4];
                    r_bcd_d     = r_step[11:4];
                    dz_d        = dz_next_q;
`ifdef DIV_FMT_SEG7_EN
                    seg_d = dz_next_q ? {4{7'h3F}} :
                            {seg7(q_step[11:8]), seg7(q_step[7:4]),
                             seg7(r_step[11:8]), seg7(r_step[7:4])};
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            q_dd_q      <= 12'h000;
            r_dd_q      <= 12'h000;
            dz_next_q   <= 1'b0;
            q_bcd_q     <= 8'h00;
            r_bcd_q     <= 8'h00;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef DIV_FMT_SEG7_EN
            seg_q       <= {4{7'h40}};
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_dd_q      <= q_dd_d;
            r_dd_q      <= r_dd_d;
            dz_next_q   <= dz_next_d;
            q_bcd_q     <= q_bcd_d;
            r_bcd_q     <= r_bcd_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef DIV_FMT_SEG7_EN
            seg_q       <= seg_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q_bcd     = q_bcd_q;
    assign r_bcd     = r_bcd_q;
    assign dz        = dz_q;
`ifdef DIV_FMT_SEG7_EN
    assign seg       = seg_q;
`endif

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Bench for div_bcd_formatter: spec-level cycle model plus scoreboard, checked every negedge,
// with literal expectations from directed vectors.
module tb_div_bcd_formatter;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready, dz;
    logic [3:0] q, r, b;
    logic [7:0] q_bcd, r_bcd;
`ifdef DIV_FMT_SEG7_EN
    logic [27:0] seg;
`endif

    always #5 clk = ~clk;

    div_bcd_formatter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .r         (r),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .dz        (dz)
`ifdef DIV_FMT_SEG7_EN
        ,
        .seg       (seg)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];
    logic [6:0]  seg_tab [0:9];
    int          m_phase = 0;
    logic [7:0]  m_q = 8'h00;
    logic [7:0]  m_r = 8'h00;
    logic        m_dz = 1'b0;
    logic [27:0] m_seg = {4{7'h40}};
    logic [16:0] m_pend = '0;
    bit          m_acc_evt = 1'b0;
    bit          chk_en = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    // Expected result word {dz, q_bcd, r_bcd} straight from decimal arithmetic.
    function automatic logic [16:0] fmt(input logic [3:0] qq, input logic [3:0] rr, input logic [3:0] bb);
        int qi, ri;
        logic z;
        logic [7:0] qb, rb;
        qi = qq;
        ri = rr;
        z  = (bb == 4'd0);
        qb = z ? 8'h00 : 8'((qi / 10) * 16 + qi % 10);
        rb = 8'((ri / 10) * 16 + ri % 10);
        return {z, qb, rb};
    endfunction

    function automatic logic [27:0] segs(input logic [16:0] res);
        if (res[16])
            return {4{7'h3F}};
        return {seg_tab[res[15:12]], seg_tab[res[11:8]], seg_tab[res[7:4]], seg_tab[res[3:0]]};
    endfunction

    // Cycle model: phase 0 idle, 1..4 converting, 5 holding a result.
    always @(posedge clk) begin
        cyc++;
        m_acc_evt = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_q     = 8'h00;
            m_r     = 8'h00;
            m_dz    = 1'b0;
            m_seg   = {4{7'h40}};
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend = fmt(q, r, b);
                    exp_q.push_back(m_pend);
                    m_acc_evt = 1'b1;
                    acc_cyc   = cyc;
                    m_phase   = 1;
                end
                1, 2, 3: m_phase++;
                4: begin
                    m_phase = 5;
                    {m_dz, m_q, m_r} = m_pend;
                    m_seg = segs(m_pend);
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 5);
            chk("q_bcd", q_bcd, m_q);
            chk("r_bcd", r_bcd, m_r);
            chk("dz", dz, m_dz);
            chk("bcd_high_bits", {q_bcd[7:5], r_bcd[7:5]}, 0);
`ifdef DIV_FMT_SEG7_EN
            chk("seg", seg, m_seg);
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h expected=none", {dz, q_bcd, r_bcd});
                end else begin
                    chk("sb_result", {dz, q_bcd, r_bcd}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] qq, input logic [3:0] rr, input logic [3:0] bb, input bit keep);
        bit ok;
        ok       = 1'b0;
        q        = qq;
        r        = rr;
        b        = bb;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_acc_evt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=none expected=accept");
        end
        if (!keep)
            in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout actual=0 expected=1");
        end
    endtask

    initial begin
        int lat, a0, a1, a2;
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; q = 4'd0; r = 4'd0; b = 4'd0;
        tick();
        chk_en = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q_bcd", q_bcd, 8'h00);
        chk("rst_r_bcd", r_bcd, 8'h00);
        chk("rst_dz", dz, 0);
`ifdef DIV_FMT_SEG7_EN
        chk("rst_seg", seg, {4{7'h40}});
`endif
        tick();
        rst = 1'b0;
        tick();

        // Single beat, latency and one-cycle pulse
        out_ready = 1'b1;
        send(4'd13, 4'd2, 4'd1, 1'b0);
        wait_out(lat);
        chk("t1_latency", lat, 4);
        chk("t1_q_bcd", q_bcd, 8'h13);
        chk("t1_r_bcd", r_bcd, 8'h02);
        chk("t1_dz", dz, 0);
        tick();
        chk("t1_pulse_end", out_valid, 0);

        // Boundary values
        send(4'd15, 4'd9, 4'd3, 1'b0);
        wait_out(lat);
        chk("t2_q_bcd", q_bcd, 8'h15);
        chk("t2_r_bcd", r_bcd, 8'h09);
        tick();
        send(4'd0, 4'd0, 4'd5, 1'b0);
        wait_out(lat);
        chk("t2_zero_q", q_bcd, 8'h00);
        chk("t2_zero_r", r_bcd, 8'h00);
        tick();

        // Divide by zero
        send(4'd0, 4'd7, 4'd0, 1'b0);
        wait_out(lat);
        chk("t3_dz", dz, 1);
        chk("t3_q_bcd", q_bcd, 8'h00);
        chk("t3_r_bcd", r_bcd, 8'h07);
`ifdef DIV_FMT_SEG7_EN
        chk("t3_seg", seg, {4{7'b0111111}});
`endif
        tick();

        // Backpressure with a competing in_valid
        out_ready = 1'b0;
        send(4'd6, 4'd4, 4'd2, 1'b0);
        wait_out(lat);
        q = 4'd9; r = 4'd1; b = 4'd3; in_valid = 1'b1;
        repeat (10) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_q_bcd", q_bcd, 8'h06);
            chk("bp_r_bcd", r_bcd, 8'h04);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        repeat (3) tick();

        // Reset during the second CONV cycle
        send(4'd9, 4'd9, 4'd1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rc_in_ready", in_ready, 1);
        repeat (8) begin
            tick();
            chk("rc_no_out_valid", out_valid, 0);
        end
        chk("rc_q_bcd", q_bcd, 8'h00);
        chk("rc_r_bcd", r_bcd, 8'h00);

        // Back-to-back with in_valid and out_ready held high
        send(4'd3, 4'd1, 4'd2, 1'b1);
        a0 = acc_cyc;
        send(4'd14, 4'd0, 4'd7, 1'b1);
        a1 = acc_cyc;
        send(4'd10, 4'd5, 4'd0, 1'b0);
        a2 = acc_cyc;
        chk("b2b_spacing_1", a1 - a0, 6);
        chk("b2b_spacing_2", a2 - a1, 6);
        wait_out(lat);
        chk("b2b_last_dz", dz, 1);
        chk("b2b_last_q", q_bcd, 8'h00);
        chk("b2b_last_r", r_bcd, 8'h05);
        repeat (4) tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
